// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_core memory-side blocks.
package riscv_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Who owns the read data that returns from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles a pending fetch has been denied.
module starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CNT_W'(1);
        end
    end

    assign sat = (count == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between fetch and load/store:
// data has priority, fetch takes over after STARVE_MAX denied cycles.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    rd_owner_e rd_owner;
    logic      starved;

    starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (if_req && !if_gnt),
        .clr (if_gnt || !if_req),
        .sat (starved)
    );

    // Fetch wins when alone or once it has been starved long enough.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if_gnt = if_req && (!d_req || starved);
            d_gnt  = d_req && !(if_req && starved);
        end
    end

    always_comb begin
        mem_en    = if_gnt || d_gnt;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_write = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else if (if_gnt) begin
            rd_owner <= OWN_IF;
        end else if (d_gnt && !d_we) begin
            rd_owner <= OWN_D;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    // A reset landing on the response cycle drops the in-flight read.
    assign if_rvalid = !rst && (rd_owner == OWN_IF);
    assign d_rvalid  = !rst && (rd_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic        mem_en, mem_write;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: how many consecutive cycles the fetch has been
    // refused, and which requester (0 none, 1 fetch, 2 data) expects data.
    int waited  = 0;
    int pending = 0;

    task automatic model_step();
        logic        f_win, d_win;
        logic [31:0] e_addr;
        f_win = !rst && if_req && (!d_req || waited >= SM);
        d_win = !rst && d_req && !f_win;
        e_addr = d_win ? d_addr : (f_win ? if_addr : 32'd0);
        chk1 ("m_if_gnt",    if_gnt,    f_win);
        chk1 ("m_d_gnt",     d_gnt,     d_win);
        chk1 ("m_mem_en",    mem_en,    f_win || d_win);
        chk1 ("m_mem_write", mem_write, d_win && d_we);
        chk32("m_mem_addr",  mem_addr,  e_addr);
        chk32("m_mem_wdata", mem_wdata, d_win ? d_wdata : 32'd0);
        chk1 ("m_if_rvalid", if_rvalid, !rst && pending == 1);
        chk1 ("m_d_rvalid",  d_rvalid,  !rst && pending == 2);
        chk32("m_if_rdata",  if_rdata,  (!rst && pending == 1) ? mem_rdata : 32'd0);
        chk32("m_d_rdata",   d_rdata,   (!rst && pending == 2) ? mem_rdata : 32'd0);
        if (rst) begin
            waited  = 0;
            pending = 0;
        end else begin
            waited  = (if_req && !f_win) ? ((waited < SM) ? waited + 1 : SM) : 0;
            pending = f_win ? 1 : ((d_win && !d_we) ? 2 : 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    logic [9:0] seen;
    logic [4:0] seen5;
    logic       any_if;

    initial begin
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h80; d_addr = 32'h90; d_wdata = 32'd0; mem_rdata = 32'h5555_AAAA;

        // reset with both requesting
        repeat (3) begin
            @(negedge clk);
            chk1("rst_if_gnt", if_gnt, 1'b0);
            chk1("rst_d_gnt", d_gnt, 1'b0);
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_if_rvalid", if_rvalid, 1'b0);
            chk1("rst_d_rvalid", d_rvalid, 1'b0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk1("rel_d_gnt", d_gnt, 1'b1);
        chk1("rel_if_gnt", if_gnt, 1'b0);
        chk1("rel_if_rvalid", if_rvalid, 1'b0);
        chk32("rel_if_rdata", if_rdata, 32'd0);
        chk32("rel_d_rdata", d_rdata, 32'd0);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // fetch alone
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk1("f_if_gnt", if_gnt, 1'b1);
        chk32("f_mem_addr", mem_addr, 32'h40);
        chk1("f_mem_write", mem_write, 1'b0);
        tick();
        if_req = 1'b0; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk1("f_if_rvalid", if_rvalid, 1'b1);
        chk32("f_if_rdata", if_rdata, 32'h0050_0093);
        chk1("f_d_rvalid", d_rvalid, 1'b0);
        tick();

        // store then load back-to-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk1("st_d_gnt", d_gnt, 1'b1);
        chk1("st_mem_write", mem_write, 1'b1);
        chk32("st_mem_addr", mem_addr, 32'h100);
        chk32("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        d_we = 1'b0; d_wdata = 32'd0;
        @(negedge clk);
        chk1("ld_no_st_rvalid", d_rvalid, 1'b0);
        chk1("ld_d_gnt", d_gnt, 1'b1);
        chk1("ld_mem_write", mem_write, 1'b0);
        tick();
        d_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("ld_d_rvalid", d_rvalid, 1'b1);
        chk32("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk1("ld_if_rvalid", if_rvalid, 1'b0);
        tick();

        // contention for 10 cycles: D,D,D,D,IF repeated
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            mem_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            seen[i] = if_gnt;
            tick();
        end
        chk32("cont_pattern", {22'd0, seen}, {22'd0, 10'b10_0001_0000});

        // reset during the response cycle of a fetch
        d_req = 1'b0; if_addr = 32'h44;
        @(negedge clk);
        chk1("rr_if_gnt", if_gnt, 1'b1);
        tick();
        rst = 1'b1; if_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("rr_if_rvalid_n1", if_rvalid, 1'b0);
        chk32("rr_if_rdata_n1", if_rdata, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("rr_if_rvalid_n2", if_rvalid, 1'b0);
        tick();

        // abandoned fetch under data contention
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; if_req = 1'b1; if_addr = 32'h600;
        any_if = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            any_if = any_if | if_gnt;
            tick();
        end
        if_req = 1'b0;
        @(negedge clk);
        any_if = any_if | if_gnt;
        tick();
        chk1("ab_no_if_gnt", any_if, 1'b0);
        if_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen5[i] = if_gnt;
            tick();
        end
        chk32("ab_restart_pattern", {27'd0, seen5}, {27'd0, 5'b10000});

        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
